// File: rtl/pa_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pa_feeder_if
// Brief    : Load-path and pa_top-side signal bundle for pa_feeder.
//            slave modport = pa_feeder side, master modport = driving side.
//            Optional underflow_cnt_o exists when PA_FEEDER_STAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface pa_feeder_if #(
    parameter int SIZE_MAT   = 16,
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 32
);
    localparam int WIDTH_PTR = $clog2(DEPTH);
    localparam int ROW_W     = SIZE_MAT * WIDTH_DATA;

    logic               flush_i;
    logic               wr_vld_i;
    logic               wr_rdy_o;
    logic [ROW_W-1:0]   wr_v_i;
    logic [ROW_W-1:0]   wr_h_i;
    logic               data_rdy_o;
    logic               read_en_i;
    logic [ROW_W-1:0]   v_bus_o;
    logic [ROW_W-1:0]   h_bus_o;
    logic [WIDTH_PTR:0] level_o;
`ifdef PA_FEEDER_STAT_EN
    logic [15:0]        underflow_cnt_o;
`endif

    modport slave (
        input  flush_i, wr_vld_i, wr_v_i, wr_h_i, read_en_i,
        output wr_rdy_o, data_rdy_o, v_bus_o, h_bus_o, level_o
`ifdef PA_FEEDER_STAT_EN
        , output underflow_cnt_o
`endif
    );

    modport master (
        output flush_i, wr_vld_i, wr_v_i, wr_h_i, read_en_i,
        input  wr_rdy_o, data_rdy_o, v_bus_o, h_bus_o, level_o
`ifdef PA_FEEDER_STAT_EN
        , input underflow_cnt_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pa_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pa_feeder
// Brief    : Row-pair FIFO staging operands for pa_top. Accepts v/h row pairs
//            via valid/ready, raises data_rdy_o once a full tile is stored and
//            serves exactly SIZE_MAT pops per tile onto registered buses.
//            Optional macro PA_FEEDER_STAT_EN adds a saturating count of
//            read_en_i cycles whose pop was not accepted (underflow_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module pa_feeder #(
    parameter int SIZE_MAT   = 16,
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 32
) (
    input  wire           clk,
    input  wire           rst,
    pa_feeder_if.slave    fb
);
    localparam int WIDTH_PTR = $clog2(DEPTH);
    localparam int C_ROW_W   = SIZE_MAT * WIDTH_DATA;
    localparam int C_CNT_W   = (SIZE_MAT > 1) ? $clog2(SIZE_MAT) : 1;

    localparam logic [WIDTH_PTR:0] C_DEPTH    = (WIDTH_PTR+1)'(DEPTH);
    localparam logic [WIDTH_PTR:0] C_TILE     = (WIDTH_PTR+1)'(SIZE_MAT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SIZE_MAT - 1);

    localparam logic [0:0] ST_WAIT  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [C_ROW_W-1:0]   r_mem_v [DEPTH];
    logic [C_ROW_W-1:0]   r_mem_h [DEPTH];
    logic [WIDTH_PTR-1:0] r_wr_ptr;
    logic [WIDTH_PTR-1:0] r_rd_ptr;
    logic [WIDTH_PTR:0]   r_level;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [0:0]           r_state;
    logic [C_ROW_W-1:0]   r_v_bus;
    logic [C_ROW_W-1:0]   r_h_bus;

    logic                 w_wr_rdy;
    logic                 w_wr_acc;
    logic                 w_pop;
    logic [WIDTH_PTR:0]   w_level_nxt;
    logic [0:0]           w_state_nxt;

    // Ready looks only at the stored level, never at a same-cycle pop.
    assign w_wr_rdy = (r_level < C_DEPTH) && !rst;
    assign w_wr_acc = fb.wr_vld_i && w_wr_rdy;
    assign w_pop    = fb.read_en_i && (r_state == ST_SERVE) && (r_level != '0);

    assign fb.wr_rdy_o   = w_wr_rdy;
    assign fb.data_rdy_o = (r_state == ST_SERVE);
    assign fb.v_bus_o    = r_v_bus;
    assign fb.h_bus_o    = r_h_bus;
    assign fb.level_o    = r_level;

    // Level after this edge; a simultaneous write and pop cancel out.
    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_wr_acc, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Tile FSM next state: enter SERVE on a full tile, re-evaluate only after
    // the last pop of the locked tile.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_WAIT: begin
                if (r_level >= C_TILE) w_state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                if (w_pop && (r_cnt == C_CNT_LAST))
                    w_state_nxt = (w_level_nxt >= C_TILE) ? ST_SERVE : ST_WAIT;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // Tile FSM state register; flush abandons any tile in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_state <= ST_WAIT;
        else if (fb.flush_i) r_state <= ST_WAIT;
        else                 r_state <= w_state_nxt;
    end

    // Row storage; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !fb.flush_i) begin
            r_mem_v[r_wr_ptr] <= fb.wr_v_i;
            r_mem_h[r_wr_ptr] <= fb.wr_h_i;
        end
    end

    // Pointers, level, tile count and registered output buses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_v_bus  <= '0;
            r_h_bus  <= '0;
        end else if (fb.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_v_bus  <= '0;
            r_h_bus  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_v_bus  <= r_mem_v[r_rd_ptr];
                r_h_bus  <= r_mem_h[r_rd_ptr];
                r_cnt    <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
            r_level <= w_level_nxt;
        end
    end

`ifdef PA_FEEDER_STAT_EN
    logic [15:0] r_underflow_cnt;

    assign fb.underflow_cnt_o = r_underflow_cnt;

    // Saturating count of cycles where pa_top asked for a row and got none.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_underflow_cnt <= '0;
        else if (fb.flush_i)
            r_underflow_cnt <= '0;
        else if (fb.read_en_i && !w_pop && (r_underflow_cnt != 16'hFFFF))
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
`endif

endmodule
`default_nettype wire

// File: doc/pa_feeder.md
Name: pa_feeder

Overview:
Operand staging buffer directly upstream of pa_top. It accepts row pairs (one v row and one h row, SIZE_MAT lanes each) from the load path through a valid/ready handshake, and stores them in a row FIFO. It presents full SIZE_MAT-row tiles to pa_top through the data_rdy/read_en protocol. Each accepted read_en pops one row pair onto registered v_bus/h_bus outputs.

Parameters:
SIZE_MAT, 16, lanes per row and rows per tile
WIDTH_DATA, 16, bits per lane
DEPTH, 32, FIFO capacity in row pairs; power of 2, >= SIZE_MAT
WIDTH_PTR, $clog2(DEPTH), pointer width (derived)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
flush_i  in  1  synchronous clear of FIFO and tile state
wr_vld_i  in  1  write row pair valid
wr_rdy_o  out  1  FIFO can accept a row pair
wr_v_i  in  SIZE_MAT*WIDTH_DATA  vertical operand row
wr_h_i  in  SIZE_MAT*WIDTH_DATA  horizontal operand row
data_rdy_o  out  1  a full tile is available; drives pa_top data_rdy_i
read_en_i  in  1  pop request from pa_top read_en_o
v_bus_o  out  SIZE_MAT*WIDTH_DATA  registered popped v row; drives pa_top v_bus_i
h_bus_o  out  SIZE_MAT*WIDTH_DATA  registered popped h row; drives pa_top h_bus_i
level_o  out  WIDTH_PTR+1  row pairs currently stored

Behaviour:
- Reset (rst high, asynchronous): pointers=0, level_o=0, data_rdy_o=0, v_bus_o=0, h_bus_o=0, state WAIT, tile count=0. wr_rdy_o=0 while rst is high.
- Write: wr_rdy_o = (level_o < DEPTH) && !rst, combinational from level. A write is accepted when wr_vld_i && wr_rdy_o; the row is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- wr_rdy_o does not look ahead to a same-cycle pop. When full, a write is refused even if a pop occurs in the same cycle.
- Pop accepted = read_en_i && state==SERVE && level_o!=0.
- On an accepted pop: v_bus_o/h_bus_o load the row at rd_ptr on that same edge, giving 1-cycle latency. rd_ptr increments modulo DEPTH.
- Non-accepted read_en_i is ignored. Outputs hold their last value.
- Level: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop. Never exceeds DEPTH or goes below 0.
- State machine (registered data_rdy_o = (state==SERVE)):
  - WAIT -> SERVE when level_o >= SIZE_MAT. data_rdy_o rises on the edge after the level condition is registered.
  - SERVE: tile count increments on each accepted pop.
  - On a pop with count==SIZE_MAT-1: count<=0. Stay in SERVE if next level >= SIZE_MAT (including a same-cycle write), else go to WAIT.
- Tile lock: once in SERVE, exactly SIZE_MAT pops are served before re-evaluation. level_o >= SIZE_MAT is guaranteed at tile entry, so a locked tile never underflows.
- flush_i (synchronous, highest priority after rst): pointers, level, and count are cleared; state goes to WAIT; buses go to 0. A write in the same cycle is dropped. Flush mid-tile abandons the tile.
- Pointer wrap: rd/wr pointers wrap DEPTH-1 -> 0; level uses the extra bit to distinguish full from empty.

Optional Feature:
Macro PA_FEEDER_STAT_EN.
- Defined: adds output underflow_cnt_o (16 bits). It is a saturating count, at 16'hFFFF, of cycles with read_en_i high and the pop not accepted. It is reset by rst and flush_i.
- Undefined: the port and counter are absent; there is no other behavioural difference.

Test Plan:
- Reset then idle: rst high 3 cycles -> all outputs 0, wr_rdy_o=0. After release -> wr_rdy_o=1, level_o=0, data_rdy_o=0.
- Write 16 rows, row i lanes = i..i+15, then hold read_en_i=1 -> data_rdy_o rises 1 cycle after level 16. Pops return rows 0..15 in order, each 1 cycle after its pop edge. data_rdy_o falls after the 16th pop; level_o=0.
- Write 15 rows, assert read_en_i -> data_rdy_o stays 0, buses stay 0, level_o stays 15. With STAT_EN, underflow_cnt_o increments each cycle.
- Fill 32 rows -> wr_rdy_o=0 and a 33rd write is refused. One pop -> wr_rdy_o=1 next cycle; after 16 pops data_rdy_o stays 1 (level 16).
- Write one row per cycle while popping continuously from level 16 -> level stays constant, data_rdy_o never drops, and the row order is preserved across the pointer wrap.
- flush_i asserted after 5 pops of a tile -> next cycle level_o=0, data_rdy_o=0, buses=0, and a same-cycle write is not stored.
